// File: rtl/gate_test_sequencer.sv
// Walks every input vector of an N-input gate, holds each for a settle interval,
// then compares the gate output against EXP_TT and reports count, first failure and pass.
module gate_test_sequencer #(
  parameter int unsigned          N_IN          = 2,
  parameter int unsigned          SETTLE_CYCLES = 4,
  parameter logic [(2**N_IN)-1:0] EXP_TT        = 4'b1001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            stop_on_fail,
  input  logic            dut_out,
  output logic [N_IN-1:0] in_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            fail_valid
);

  localparam int unsigned VEC_W = N_IN;
  localparam int unsigned ERR_W = N_IN + 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [VEC_W-1:0] LAST_VEC = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0]  in_vec_q, in_vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [VEC_W-1:0]  first_fail_vec_q, first_fail_vec_d;
  logic              fail_valid_q, fail_valid_d;
  logic              mismatch_c;

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      in_vec_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_fail_vec_q <= '0;
      fail_valid_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      in_vec_q         <= in_vec_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_fail_vec_q <= first_fail_vec_d;
      fail_valid_q     <= fail_valid_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    in_vec_d         = in_vec_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_fail_vec_d = first_fail_vec_q;
    fail_valid_d     = fail_valid_q;
    mismatch_c       = (dut_out != EXP_TT[in_vec_q]);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d          = ST_SETTLE;
          cnt_d            = '0;
          in_vec_d         = '0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          err_count_d      = '0;
          first_fail_vec_d = '0;
          fail_valid_d     = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // Abort pre-empts the compare scheduled for this cycle
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (mismatch_c) begin
            err_count_d = err_count_q + ERR_W'(1);
            if (!fail_valid_q) begin
              first_fail_vec_d = in_vec_q;
              fail_valid_d     = 1'b1;
            end
          end
          if ((in_vec_q == LAST_VEC) || (mismatch_c && stop_on_fail)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end else begin
            state_d  = ST_SETTLE;
            in_vec_d = in_vec_q + VEC_W'(1);
            cnt_d    = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_vec         = in_vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_fail_vec = first_fail_vec_q;
  assign fail_valid     = fail_valid_q;

endmodule
